// File: rtl/vga_frame_scanner_if.sv
// Framebuffer read port and VGA pin bundle for vga_frame_scanner.
// The read port has no handshake: pixel is valid a fixed MEM_LATENCY clocks after DataAdrVGA changes.
interface vga_frame_scanner_if;
  logic [31:0] pixel;
  logic [31:0] DataAdrVGA;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_blank_n;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        frame_start;

  modport master (
    input  pixel,
    output DataAdrVGA, vga_hsync, vga_vsync, vga_blank_n,
           vga_r, vga_g, vga_b, frame_start
  );

  modport slave (
    output pixel,
    input  DataAdrVGA, vga_hsync, vga_vsync, vga_blank_n,
           vga_r, vga_g, vga_b, frame_start
  );
endinterface

// File: rtl/vga_frame_scanner.sv
// VGA timing generator and framebuffer scanner with power-of-two upscaling.
// Sync and blank flags ride a PIPE-deep delay line so they leave aligned with the colour.
module vga_frame_scanner #(
  parameter int H_ACTIVE         = 640,
  parameter int H_FP             = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BP             = 48,
  parameter int V_ACTIVE         = 480,
  parameter int V_FP             = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BP             = 33,
  parameter int SYNC_ACTIVE_HIGH = 0,
  parameter int IMG_W            = 256,
  parameter int IMG_H            = 256,
  parameter int IMG_X0           = 0,
  parameter int IMG_Y0           = 0,
  parameter int SCALE_LOG2       = 0,
  parameter int MEM_LATENCY      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enabled,
  input  logic                  color_mode,
  input  logic [23:0]           bg_color,
  vga_frame_scanner_if.master   bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PIPE    = MEM_LATENCY + 2;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [31:0] H_ACT32 = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT32 = 32'(V_ACTIVE);
  localparam logic [31:0] HS_LO   = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_HI   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_LO   = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_HI   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] X_LO    = 32'(IMG_X0);
  localparam logic [31:0] X_HI    = 32'(IMG_X0 + (IMG_W << SCALE_LOG2));
  localparam logic [31:0] Y_LO    = 32'(IMG_Y0);
  localparam logic [31:0] Y_HI    = 32'(IMG_Y0 + (IMG_H << SCALE_LOG2));
  localparam logic        SYNC_ON = 1'(SYNC_ACTIVE_HIGH);

  // Everything the output stage needs to know about one screen position.
  typedef struct packed {
    logic fs;
    logic hs;
    logic vs;
    logic act;
    logic img;
    logic en;
    logic cm;
  } flags_t;

  logic [HW-1:0] hx;
  logic [VW-1:0] vy;
  logic          en_lat;
  logic          cm_lat;
  logic [31:0]   hx32;
  logic [31:0]   vy32;
  logic [31:0]   dx;
  logic [31:0]   dy;
  logic [31:0]   src_adr;
  logic          at_origin;
  flags_t        cur;
  flags_t        dly [PIPE-1];
  flags_t        last;
  logic [23:0]   next_rgb;
  logic          unused_pixel_bits;

  assign unused_pixel_bits = ^bus.pixel[31:24];

  always_comb begin
    hx32      = 32'(hx);
    vy32      = 32'(vy);
    dx        = hx32 - X_LO;
    dy        = vy32 - Y_LO;
    src_adr   = (dy >> SCALE_LOG2) * 32'(IMG_W) + (dx >> SCALE_LOG2);
    at_origin = (hx == '0) && (vy == '0);
    cur       = '0;
    cur.fs    = at_origin;
    cur.hs    = (hx32 >= HS_LO) && (hx32 < HS_HI);
    cur.vs    = (vy32 >= VS_LO) && (vy32 < VS_HI);
    cur.act   = (hx32 < H_ACT32) && (vy32 < V_ACT32);
    cur.img   = cur.act && (hx32 >= X_LO) && (hx32 < X_HI)
                        && (vy32 >= Y_LO) && (vy32 < Y_HI);
    // The frame's own origin pixel already sees the freshly sampled mode bits.
    cur.en    = at_origin ? enabled    : en_lat;
    cur.cm    = at_origin ? color_mode : cm_lat;
  end

  always_comb begin
    last     = dly[PIPE-2];
    next_rgb = '0;
    if (!last.act)     next_rgb = '0;
    else if (!last.en) next_rgb = 24'hFF_FFFF;
    else if (!last.img) next_rgb = bg_color;
    else if (last.cm)  next_rgb = bus.pixel[23:0];
    else               next_rgb = {3{bus.pixel[7:0]}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hx              <= '0;
      vy              <= '0;
      en_lat          <= 1'b0;
      cm_lat          <= 1'b0;
      bus.DataAdrVGA  <= '0;
      for (int i = 0; i < PIPE-1; i++) dly[i] <= '0;
      bus.vga_hsync   <= ~SYNC_ON;
      bus.vga_vsync   <= ~SYNC_ON;
      bus.vga_blank_n <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.vga_r       <= '0;
      bus.vga_g       <= '0;
      bus.vga_b       <= '0;
    end else begin
      if (hx == HW'(H_TOTAL-1)) begin
        hx <= '0;
        vy <= (vy == VW'(V_TOTAL-1)) ? '0 : vy + 1'b1;
      end else begin
        hx <= hx + 1'b1;
      end
      if (at_origin) begin
        en_lat <= enabled;
        cm_lat <= color_mode;
      end
      if (cur.img) bus.DataAdrVGA <= src_adr;
      dly[0] <= cur;
      for (int i = 1; i < PIPE-1; i++) dly[i] <= dly[i-1];
      bus.vga_hsync   <= last.hs ? SYNC_ON : ~SYNC_ON;
      bus.vga_vsync   <= last.vs ? SYNC_ON : ~SYNC_ON;
      bus.vga_blank_n <= last.act;
      bus.frame_start <= last.fs;
      bus.vga_r       <= next_rgb[23:16];
      bus.vga_g       <= next_rgb[15:8];
      bus.vga_b       <= next_rgb[7:0];
    end
  end
endmodule

// File: tb/tb_vga_frame_scanner.sv
// Randomised bench for vga_frame_scanner in a small video mode, checked every clock
// against a raster model computed directly from screen coordinates.
module tb_vga_frame_scanner;
  localparam int HA = 40, HF = 4, HS = 6, HB = 6;
  localparam int VA = 20, VF = 2, VS = 2, VB = 3;
  localparam int IW = 16, IH = 8, X0 = 10, Y0 = 4, SL = 1, ML = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int PIPE = ML + 2;
  localparam int MID_RST_N = 3 * FRAME + 10 * HT + 30;
  localparam int TOTAL_CYCLES = 5 * FRAME + 800;
  localparam logic SON = 1'b0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enabled = 1'b0;
  logic        color_mode = 1'b0;
  logic [23:0] bg_color = 24'h123456;

  int n_checks = 0;
  int n_errors = 0;

  logic frame_en [64];
  logic frame_cm [64];
  logic [31:0] ram_q [ML];

  vga_frame_scanner_if bus();

  vga_frame_scanner #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE_HIGH(0),
    .IMG_W(IW), .IMG_H(IH), .IMG_X0(X0), .IMG_Y0(Y0),
    .SCALE_LOG2(SL), .MEM_LATENCY(ML)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enabled(enabled),
    .color_mode(color_mode),
    .bg_color(bg_color),
    .bus(bus)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // framebuffer RAM model: contents are a hash of the address
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
  endfunction

  always @(posedge clk) begin
    ram_q[0] <= ram_word(bus.DataAdrVGA);
    for (int i = 1; i < ML; i++) ram_q[i] <= ram_q[i-1];
  end
  assign bus.pixel = ram_q[ML-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model over screen coordinates
  function automatic bit in_image(input int x, input int y);
    return x >= X0 && x < X0 + IW * (2 ** SL) && x < HA &&
           y >= Y0 && y < Y0 + IH * (2 ** SL) && y < VA;
  endfunction

  function automatic logic [31:0] addr_of(input int x, input int y);
    return 32'(((y - Y0) / (2 ** SL)) * IW + (x - X0) / (2 ** SL));
  endfunction

  function automatic logic [27:0] model_out(input int n, input logic [23:0] bg);
    int p, x, y, f;
    logic hs, vs, act, fs;
    logic [23:0] rgb;
    logic [31:0] w;
    if (n < PIPE) return {~SON, ~SON, 1'b0, 1'b0, 24'h0};
    p   = n - PIPE;
    x   = p % HT;
    y   = (p / HT) % VT;
    f   = (p / FRAME) % 64;
    act = x < HA && y < VA;
    fs  = (p % FRAME) == 0;
    hs  = (x >= HA + HF && x < HA + HF + HS) ? SON : ~SON;
    vs  = (y >= VA + VF && y < VA + VF + VS) ? SON : ~SON;
    if (!act) rgb = 24'h0;
    else if (!frame_en[f]) rgb = 24'hFF_FFFF;
    else if (in_image(x, y)) begin
      w   = ram_word(addr_of(x, y));
      rgb = frame_cm[f] ? w[23:0] : {3{w[7:0]}};
    end else rgb = bg;
    return {hs, vs, act, fs, rgb};
  endfunction

  initial begin
    int n;
    int q;
    bit did_mid;
    bit mid_pending;
    logic [31:0] last_addr;
    n = 0;
    did_mid = 1'b0;
    mid_pending = 1'b0;
    last_addr = '0;
    for (int cyc = 0; cyc < TOTAL_CYCLES; cyc++) begin
      @(negedge clk);
      if (reset) begin
        n = 0;
        last_addr = '0;
      end else begin
        n++;
        q = n - 1;
        if (in_image(q % HT, (q / HT) % VT)) last_addr = addr_of(q % HT, (q / HT) % VT);
      end

      if (mid_pending) begin
        check("mid_reset_outputs",
              {bus.vga_hsync, bus.vga_vsync, bus.vga_blank_n, bus.frame_start,
               bus.vga_r, bus.vga_g, bus.vga_b, bus.DataAdrVGA},
              {~SON, ~SON, 1'b0, 1'b0, 24'h0, 32'h0});
        mid_pending = 1'b0;
      end
      check("dataadr", bus.DataAdrVGA, last_addr);
      check("video",
            {bus.vga_hsync, bus.vga_vsync, bus.vga_blank_n, bus.frame_start,
             bus.vga_r, bus.vga_g, bus.vga_b},
            model_out(n, bg_color));

      // driver: stimulus for the next clock edge
      if ($urandom_range(0, 299) == 0) enabled = ~enabled;
      if ($urandom_range(0, 299) == 0) color_mode = ~color_mode;
      if ($urandom_range(0, 99) == 0) bg_color = 24'($urandom);
      if (cyc == FRAME / 2) enabled = 1'b1;
      reset = (cyc < 3);
      if (!did_mid && n == MID_RST_N) begin
        reset = 1'b1;
        did_mid = 1'b1;
        mid_pending = 1'b1;
      end
      if (n % FRAME == 0) begin
        frame_en[(n / FRAME) % 64] = enabled;
        frame_cm[(n / FRAME) % 64] = color_mode;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
